wb_regfile_unit: RTL and testbench

WB_REGFILE_UNIT -- requirements
Module: wb_regfile_unit

---
 rtl/wb_regfile_unit.sv | 90 +++++++++
 tb/tb_wb_regfile_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_unit.sv
// wb_regfile_unit
// Write-back stage register file: four 8-bit registers (R3 doubles as the
// stack pointer after reset), a 4-bit condition code register, a registered
// output port and a registered return-address pulse for RET.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   wb_reg_write, write_addr  register write strobe and destination
//   alu_result, mem_data,     write data sources; io_read > mem_to_reg > ALU
//   in_port, io_read,
//   mem_to_reg
//   sp_update, sp_addr        stack-pointer write of alu_result
//   flags_in, update_flags    CCR load
//   io_write                  out_port load of alu_result
//   is_ret                    latch mem_data into ret_pc, pulse ret_valid
//   rd_addr_a/b, rd_data_a/b  combinational reads with write-through bypass
//   ccr, out_port, ret_pc,    registered state outputs
//   ret_valid
module wb_regfile_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       wb_reg_write,
  input  logic [7:0] alu_result,
  input  logic [1:0] write_addr,
  input  logic [3:0] flags_in,
  input  logic       update_flags,
  input  logic       mem_to_reg,
  input  logic       io_read,
  input  logic       io_write,
  input  logic [7:0] mem_data,
  input  logic       sp_update,
  input  logic [1:0] sp_addr,
  input  logic       is_ret,
  input  logic [7:0] in_port,
  input  logic [1:0] rd_addr_a,
  input  logic [1:0] rd_addr_b,
  output logic [7:0] rd_data_a,
  output logic [7:0] rd_data_b,
  output logic [3:0] ccr,
  output logic [7:0] out_port,
  output logic [7:0] ret_pc,
  output logic       ret_valid
);

  logic [7:0] regs [4];
  logic [7:0] nxt  [4];
  logic [7:0] wr_data;

  // nxt is the register file as it will look after this edge. Reads come
  // straight from it, which gives the write-through bypass for free. The
  // register write is applied after the SP write so it wins on a collision.
  // Writes are masked during reset so reads show the reset contents.
  always_comb begin
    wr_data = io_read ? in_port : (mem_to_reg ? mem_data : alu_result);
    for (int i = 0; i < 4; i++) begin
      nxt[i] = regs[i];
      if (!rst && sp_update && sp_addr == 2'(i))
        nxt[i] = alu_result;
      if (!rst && wb_reg_write && write_addr == 2'(i))
        nxt[i] = wr_data;
    end
  end

  assign rd_data_a = nxt[rd_addr_a];
  assign rd_data_b = nxt[rd_addr_b];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs[0]   <= 8'h00;
      regs[1]   <= 8'h00;
      regs[2]   <= 8'h00;
      regs[3]   <= 8'hFF;
      ccr       <= 4'h0;
      out_port  <= 8'h00;
      ret_pc    <= 8'h00;
      ret_valid <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        regs[i] <= nxt[i];
      if (update_flags)
        ccr <= flags_in;
      if (io_write)
        out_port <= alu_result;
      if (is_ret)
        ret_pc <= mem_data;
      ret_valid <= is_ret;
    end
  end

endmodule

// File: tb/tb_wb_regfile_unit.sv
module tb_wb_regfile_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wb_reg_write = 1'b0;
  logic [7:0] alu_result = '0;
  logic [1:0] write_addr = '0;
  logic [3:0] flags_in = '0;
  logic       update_flags = 1'b0;
  logic       mem_to_reg = 1'b0;
  logic       io_read = 1'b0;
  logic       io_write = 1'b0;
  logic [7:0] mem_data = '0;
  logic       sp_update = 1'b0;
  logic [1:0] sp_addr = 2'd3;
  logic       is_ret = 1'b0;
  logic [7:0] in_port = '0;
  logic [1:0] rd_addr_a = '0;
  logic [1:0] rd_addr_b = '0;
  logic [7:0] rd_data_a, rd_data_b, out_port, ret_pc;
  logic [3:0] ccr;
  logic       ret_valid;

  wb_regfile_unit dut (
    .clk(clk), .rst(rst), .wb_reg_write(wb_reg_write), .alu_result(alu_result),
    .write_addr(write_addr), .flags_in(flags_in), .update_flags(update_flags),
    .mem_to_reg(mem_to_reg), .io_read(io_read), .io_write(io_write),
    .mem_data(mem_data), .sp_update(sp_update), .sp_addr(sp_addr),
    .is_ret(is_ret), .in_port(in_port), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .ccr(ccr), .out_port(out_port), .ret_pc(ret_pc), .ret_valid(ret_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, wr, uf, m2r, ior, iow, spu, isret;
    logic [7:0] alu, mem, inp;
    logic [1:0] waddr, spa, ra, rb;
    logic [3:0] flags;
  } stim_t;

  typedef struct {
    logic [7:0] a, b, outp, retpc;
    logic [3:0] ccr;
    logic       retv;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // reference state
  logic [7:0] m_r [4];
  logic [3:0] m_ccr;
  logic [7:0] m_out, m_retpc;
  logic       m_retv;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%02h expected=%02h t=%0t", nm, act, expv, $time);
    end
  endtask

  // monitor: compares whatever the driver queued for this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd_data_a", rd_data_a, e.a);
        chk("rd_data_b", rd_data_b, e.b);
        chk("ccr", {4'h0, ccr}, {4'h0, e.ccr});
        chk("out_port", out_port, e.outp);
        chk("ret_pc", ret_pc, e.retpc);
        chk("ret_valid", {7'h0, ret_valid}, {7'h0, e.retv});
      end
    end
  end

  task automatic apply(input stim_t s);
    exp_t e;
    logic [7:0] view [4];
    logic [7:0] wd;
    @(posedge clk);
    #1;
    rst = s.rst; wb_reg_write = s.wr; alu_result = s.alu; write_addr = s.waddr;
    flags_in = s.flags; update_flags = s.uf; mem_to_reg = s.m2r; io_read = s.ior;
    io_write = s.iow; mem_data = s.mem; sp_update = s.spu; sp_addr = s.spa;
    is_ret = s.isret; in_port = s.inp; rd_addr_a = s.ra; rd_addr_b = s.rb;
    if (s.rst) begin
      m_r[0] = 8'h00; m_r[1] = 8'h00; m_r[2] = 8'h00; m_r[3] = 8'hFF;
      m_ccr = 4'h0; m_out = 8'h00; m_retpc = 8'h00; m_retv = 1'b0;
    end
    view = m_r;
    if (!s.rst) begin
      if (s.ior) wd = s.inp;
      else if (s.m2r) wd = s.mem;
      else wd = s.alu;
      if (s.spu) view[s.spa] = s.alu;
      if (s.wr) view[s.waddr] = wd;
    end
    e.a = view[s.ra]; e.b = view[s.rb];
    e.ccr = m_ccr; e.outp = m_out; e.retpc = m_retpc; e.retv = m_retv;
    sb.push_back(e);
    if (!s.rst) begin
      m_r = view;
      if (s.uf) m_ccr = s.flags;
      if (s.iow) m_out = s.alu;
      if (s.isret) m_retpc = s.mem;
      m_retv = s.isret;
    end
  endtask

  function automatic stim_t idle(input logic [1:0] ra, input logic [1:0] rb);
    stim_t s;
    s = '{rst: 1'b0, wr: 1'b0, uf: 1'b0, m2r: 1'b0, ior: 1'b0, iow: 1'b0,
          spu: 1'b0, isret: 1'b0, alu: 8'h00, mem: 8'h00, inp: 8'h00,
          waddr: 2'd0, spa: 2'd3, ra: ra, rb: rb, flags: 4'h0};
    return s;
  endfunction

  initial begin
    stim_t s;
    // reset contents: R3 reads FF, R0 reads 00
    s = idle(2'd3, 2'd0); s.rst = 1'b1;
    apply(s);
    apply(s);
    apply(idle(2'd3, 2'd0));
    // IN beats memory load; bypass on same-cycle read
    s = idle(2'd1, 2'd1); s.wr = 1; s.waddr = 2'd1; s.ior = 1; s.m2r = 1;
    s.inp = 8'h5A; s.mem = 8'h33;
    apply(s);
    apply(idle(2'd1, 2'd0));
    // POP: SP and destination both commit
    s = idle(2'd3, 2'd2); s.spu = 1; s.spa = 2'd3; s.alu = 8'hFE;
    s.wr = 1; s.waddr = 2'd2; s.m2r = 1; s.mem = 8'h77;
    apply(s);
    apply(idle(2'd3, 2'd2));
    // collision on index 3: register write wins
    s = idle(2'd3, 2'd3); s.spu = 1; s.spa = 2'd3; s.alu = 8'h10;
    s.wr = 1; s.waddr = 2'd3; s.m2r = 1; s.mem = 8'h20;
    apply(s);
    apply(idle(2'd3, 2'd1));
    // RET pulse, then back-to-back RETs
    s = idle(2'd0, 2'd1); s.isret = 1; s.mem = 8'h42;
    apply(s);
    apply(idle(2'd0, 2'd1));
    apply(idle(2'd0, 2'd1));
    s.mem = 8'h11; apply(s);
    s.mem = 8'h22; apply(s);
    apply(idle(2'd0, 2'd1));
    apply(idle(2'd0, 2'd1));
    // flags and OUT, then reset mid-cycle clears both; in-flight write dropped
    s = idle(2'd2, 2'd3); s.uf = 1; s.flags = 4'b1010; s.iow = 1; s.alu = 8'hC3;
    apply(s);
    apply(idle(2'd2, 2'd3));
    s = idle(2'd2, 2'd3); s.rst = 1; s.wr = 1; s.waddr = 2'd2; s.alu = 8'h99;
    s.uf = 1; s.flags = 4'hF; s.iow = 1;
    apply(s);
    apply(idle(2'd2, 2'd3));
    // randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      s.rst   = ($urandom_range(0, 39) == 0);
      s.wr    = 1'($urandom);  s.uf  = 1'($urandom); s.m2r = 1'($urandom);
      s.ior   = 1'($urandom);  s.iow = 1'($urandom); s.spu = 1'($urandom);
      s.isret = 1'($urandom);
      s.alu   = 8'($urandom);  s.mem = 8'($urandom); s.inp = 8'($urandom);
      s.waddr = 2'($urandom);  s.spa = 2'($urandom);
      s.ra    = 2'($urandom);  s.rb  = 2'($urandom);
      s.flags = 4'($urandom);
      apply(s);
    end
    apply(idle(2'd0, 2'd3));
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
